// File: rtl/hssi_mb_cmd_ctrl.sv
// Mailbox command controller: turns host mailbox writes into single Avalon-MM
// accesses to the traffic controller. Define MB_TIMEOUT_EN to add a stall timeout.
module hssi_mb_cmd_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wrdata,
    output logic              cmd_ready,
    output logic              mb_busy,
    output logic              mb_ack,
    output logic              mb_err,
    output logic [DATA_W-1:0] mb_rddata,
    output logic              tc_read,
    output logic              tc_write,
    output logic [ADDR_W-1:0] tc_addr,
    output logic [DATA_W-1:0] tc_writedata,
    input  logic              tc_waitrequest,
    input  logic [DATA_W-1:0] tc_readdata,
    input  logic              tc_readdatavalid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] OP_NOOP = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WR   = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [1:0]        op_q,     op_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;
    logic              ack_q,    ack_d;
    logic              err_q,    err_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;

    logic accept;
    logic waiting;
    logic timeout_fire;
    logic tmo_pend;

    assign accept  = cmd_valid && (state_q == ST_IDLE);
    assign waiting = (state_q == ST_REQ) || (state_q == ST_RDWAIT);

`ifdef MB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             cnt_hit;

    assign cnt_hit = waiting && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // A handshake completing in the expiry cycle wins over the timeout.
    assign timeout_fire = cnt_hit
                          && !((state_q == ST_REQ) && !tc_waitrequest)
                          && !((state_q == ST_RDWAIT) && tc_readdatavalid);

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (accept) begin
            cnt_d = '0;
            tmo_d = 1'b0;
        end else if (timeout_fire) begin
            tmo_d = 1'b1;
        end else if (waiting && !cnt_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo_pend = tmo_q;
`else
    assign timeout_fire = 1'b0;
    assign tmo_pend     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        ack_d    = ack_q;
        err_d    = err_q;
        rddata_d = rddata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    addr_d   = cmd_addr;
                    wrdata_d = cmd_wrdata;
                    ack_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ((cmd_op == OP_RD) || (cmd_op == OP_WR)) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (!tc_waitrequest) begin
                    state_d = (op_q == OP_WR) ? ST_DONE : ST_RDWAIT;
                end else if (timeout_fire) begin
                    rddata_d = '1;
                    state_d  = ST_DONE;
                end
            end
            ST_RDWAIT: begin
                if (tc_readdatavalid) begin
                    rddata_d = tc_readdata;
                    state_d  = ST_DONE;
                end else if (timeout_fire) begin
                    rddata_d = '1;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                ack_d   = 1'b1;
                err_d   = (op_q == OP_RSVD) || tmo_pend;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOOP;
            addr_q   <= '0;
            wrdata_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rddata_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rddata_q <= rddata_d;
        end
    end

    // Strobes decode straight from state so reset removes them without waiting for a clock.
    assign tc_read      = (state_q == ST_REQ) && (op_q == OP_RD);
    assign tc_write     = (state_q == ST_REQ) && (op_q == OP_WR);
    assign tc_addr      = addr_q;
    assign tc_writedata = wrdata_q;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign mb_busy   = (state_q != ST_IDLE);
    assign mb_ack    = ack_q;
    assign mb_err    = err_q;
    assign mb_rddata = rddata_q;

endmodule

// File: tb/tb_hssi_mb_cmd_ctrl.sv
// Self-checking bench for hssi_mb_cmd_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level latency/result model.
module tb_hssi_mb_cmd_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wrdata = '0;
    logic        cmd_ready;
    logic        mb_busy;
    logic        mb_ack;
    logic        mb_err;
    logic [31:0] mb_rddata;
    logic        tc_read;
    logic        tc_write;
    logic [15:0] tc_addr;
    logic [31:0] tc_writedata;
    logic        tc_waitrequest = 1'b0;
    logic [31:0] tc_readdata = '0;
    logic        tc_readdatavalid = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rddata = '0;
    logic        exp_ack = 1'b0;
    logic        exp_err = 1'b0;

    hssi_mb_cmd_ctrl #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wrdata(cmd_wrdata),
        .cmd_ready(cmd_ready), .mb_busy(mb_busy), .mb_ack(mb_ack), .mb_err(mb_err),
        .mb_rddata(mb_rddata),
        .tc_read(tc_read), .tc_write(tc_write), .tc_addr(tc_addr), .tc_writedata(tc_writedata),
        .tc_waitrequest(tc_waitrequest), .tc_readdata(tc_readdata),
        .tc_readdatavalid(tc_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One mailbox transaction. w = waitrequest cycles, d = idle RDWAIT cycles before readdatavalid.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data,
                           input int w, input int d, input logic [31:0] rdval,
                           input bit busy_cmd, input bit stray, input bit tmo_case);
        int  lat, strobes, exp_strobes, k;
        bit  is_mem, done, in_rdwait;
        is_mem = (op == 2'd1) || (op == 2'd2);
        if (tmo_case) begin
            lat         = TMO + 2;
            exp_strobes = TMO;
        end else begin
            lat         = is_mem ? (w + 1) + ((op == 2'd1) ? d + 1 : 0) + 2 : 2;
            exp_strobes = is_mem ? w + 1 : 0;
        end
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_addr   = addr;
        cmd_wrdata = data;
        step();
        cmd_valid  = 1'b0;
        cmd_addr   = 16'($urandom);
        cmd_wrdata = $urandom;
        k = 1; strobes = 0; done = 0;
        while (!done && k <= lat + 50) begin
            tc_waitrequest   = tmo_case ? 1'b1 : (k <= w);
            tc_readdatavalid = 1'b0;
            tc_readdata      = $urandom;
            in_rdwait = (op == 2'd1) && !tmo_case && (k >= w + 2) && (k <= w + d + 2);
            if (!tmo_case && op == 2'd1 && k == w + d + 2) begin
                tc_readdatavalid = 1'b1;
                tc_readdata      = rdval;
            end else if (stray && !in_rdwait && $urandom_range(0, 1) == 1) begin
                tc_readdatavalid = 1'b1;
            end
            if (busy_cmd && k == 2) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            checks++;
            if ((tc_read & tc_write) !== 1'b0) begin
                errors++;
                $display("FAIL both_strobes cycle %0d: read=%b write=%b, required not both high", k, tc_read, tc_write);
            end
            if (tc_read === 1'b1 || tc_write === 1'b1) begin
                strobes++;
                checks++;
                if (tc_read !== (op == 2'd1) || tc_addr !== addr) begin
                    errors++;
                    $display("FAIL strobe_kind cycle %0d: read=%b addr=%h, required read=%b addr=%h",
                             k, tc_read, tc_addr, op == 2'd1, addr);
                end
                if (tc_write === 1'b1) begin
                    checks++;
                    if (tc_writedata !== data) begin
                        errors++;
                        $display("FAIL writedata: got %h, required %h", tc_writedata, data);
                    end
                end
            end
            if (k == 1) begin
                checks++;
                if (mb_ack !== 1'b0 || mb_err !== 1'b0) begin
                    errors++;
                    $display("FAIL accept_clear: ack=%b err=%b, required 0 0", mb_ack, mb_err);
                end
            end
            if (k < lat) begin
                checks++;
                if (mb_busy !== 1'b1 || cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy cycle %0d: busy=%b ready=%b, required 1 0", k, mb_busy, cmd_ready);
                end
            end
            if (cmd_ready === 1'b1) begin
                done = 1;
            end else begin
                step();
                k++;
            end
        end
        cmd_valid        = 1'b0;
        tc_readdatavalid = 1'b0;
        tc_waitrequest   = 1'b0;
        if (tmo_case) exp_rddata = 32'hFFFF_FFFF;
        else if (op == 2'd1) exp_rddata = rdval;
        exp_ack = 1'b1;
        exp_err = (op == 2'd3) || tmo_case;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL completion: cmd_ready never returned within %0d cycles", lat + 50);
        end else if (k != lat) begin
            errors++;
            $display("FAIL latency op=%0d: ready at cycle %0d, required %0d", op, k, lat);
        end
        checks++;
        if (strobes != exp_strobes) begin
            errors++;
            $display("FAIL strobe_count op=%0d: got %0d, required %0d", op, strobes, exp_strobes);
        end
        checks++;
        if (mb_ack !== exp_ack || mb_err !== exp_err || mb_rddata !== exp_rddata) begin
            errors++;
            $display("FAIL result op=%0d: ack=%b err=%b rddata=%h, required %b %b %h",
                     op, mb_ack, mb_err, mb_rddata, exp_ack, exp_err, exp_rddata);
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            tc_readdatavalid = $urandom_range(0, 1) == 1;
            tc_readdata      = $urandom;
            step();
            checks++;
            if (mb_ack !== exp_ack || mb_err !== exp_err || mb_rddata !== exp_rddata ||
                cmd_ready !== 1'b1 || tc_read !== 1'b0 || tc_write !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: ack=%b err=%b rddata=%h ready=%b, required %b %b %h 1",
                         mb_ack, mb_err, mb_rddata, cmd_ready, exp_ack, exp_err, exp_rddata);
            end
        end
        tc_readdatavalid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        step();
        step();
        checks++;
        if ({cmd_ready, mb_busy, mb_ack, mb_err, tc_read, tc_write} !== 6'b0 ||
            mb_rddata !== 32'h0 || tc_addr !== 16'h0 || tc_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b busy=%b ack=%b err=%b rddata=%h, required all 0",
                     cmd_ready, mb_busy, mb_ack, mb_err, mb_rddata);
        end
        rst = 1'b0;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || mb_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1 0", cmd_ready, mb_busy);
        end
        exp_rddata = '0; exp_ack = 1'b0; exp_err = 1'b0;
    endtask

    // Abort a stalled write with an asynchronous reset pulse in mid-cycle.
    task automatic abort_with_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tc_write !== 1'b0 || tc_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_async_drop: write=%b read=%b, required 0 0", tag, tc_write, tc_read);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tc_waitrequest = 1'b0;
        step();
        exp_rddata = '0; exp_ack = 1'b0; exp_err = 1'b0;
        checks++;
        if (mb_ack !== 1'b0 || mb_err !== 1'b0 || mb_busy !== 1'b0 || cmd_ready !== 1'b1 || mb_rddata !== 32'h0) begin
            errors++;
            $display("FAIL %s_after: ack=%b err=%b busy=%b ready=%b rddata=%h, required 0 0 0 1 0",
                     tag, mb_ack, mb_err, mb_busy, cmd_ready, mb_rddata);
        end
    endtask

    task automatic start_stuck_write();
        tc_waitrequest = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 16'h0042; cmd_wrdata = 32'hA5A5_0001;
        step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if (tc_write !== 1'b1 || tc_addr !== 16'h0042) begin
            errors++;
            $display("FAIL stuck_write: write=%b addr=%h, required 1 0042", tc_write, tc_addr);
        end
    endtask

    task automatic test_write();
        run_txn(2'd2, 16'h0003, 32'h1, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_read();
        run_txn(2'd1, 16'h0101, 32'h0, 3, 1, 32'h0000_0040, 0, 0, 0);
    endtask

    task automatic test_reserved_then_noop();
        run_txn(2'd3, 16'h0777, 32'h5, 0, 0, 32'h0, 0, 0, 0);
        run_txn(2'd0, 16'h0000, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_ignore_busy_and_stray();
        run_txn(2'd1, 16'h0200, 32'h0, 2, 2, 32'hDEAD_BEEF, 1, 1, 0);
        idle_gap(4);
    endtask

    task automatic test_reset_mid();
        start_stuck_write();
        abort_with_reset("reset_mid");
    endtask

    task automatic test_timeout();
`ifdef MB_TIMEOUT_EN
        run_txn(2'd1, 16'h0300, 32'h0, 0, 0, 32'h0, 0, 0, 1);
        run_txn(2'd2, 16'h0301, 32'h9, 0, 0, 32'h0, 0, 0, 1);
`else
        start_stuck_write();
        for (int i = 0; i < 1000; i++) step();
        checks++;
        if (mb_busy !== 1'b1 || tc_write !== 1'b1 || mb_err !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: busy=%b write=%b err=%b, required 1 1 0", mb_busy, tc_write, mb_err);
        end
        abort_with_reset("no_timeout");
`endif
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            op = 2'($urandom);
            run_txn(op, 16'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4), $urandom,
                    ((op == 2'd1) || (op == 2'd2)) && ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 1) == 1, 0);
            idle_gap($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reserved_then_noop();
        test_ignore_busy_and_stray();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
